// File: rtl/hatch_pkg.sv
// Shared types and frame constants for the egg-hatch sequencer.
// Combinational helpers only; no latency and no backpressure.
package hatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INCUBATE,
    PAUSE,
    HATCHED,
    FAILED
  } hatch_state_t;

  localparam logic [3:0] FRAME_EGG     = 4'd0;
  localparam logic [3:0] FRAME_HATCHED = 4'd9;
  localparam logic [3:0] FRAME_FAILED  = 4'd10;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hatch_in_cond.sv
// Input conditioner: 2-flop synchronizer, plus a stability debouncer when HATCH_DEBOUNCE_EN is defined.
// Latency: 2 cycles, or 2+DEB_CYC with the debouncer; no backpressure.
module hatch_in_cond #(
  parameter int unsigned DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic cond
);

  logic [1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], raw};
    end
  end

`ifdef HATCH_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYC + 1);

  logic [DW-1:0] deb_cnt;
  logic          deb_q;

  // The count only runs while the synchronized level disagrees with the held one,
  // so any return to the held level restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      deb_q   <= 1'b0;
    end else if (sync[1] == deb_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
      deb_cnt <= '0;
      deb_q   <= sync[1];
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign cond = deb_q;
`else
  assign cond = sync[1];
`endif

endmodule

// File: rtl/hatch_seq.sv
// Egg-hatch sequencer driving frame index and enables for the 8x8 display (debounce via HATCH_DEBOUNCE_EN).
// All outputs registered; inputs act on the 3rd edge after a change (+DEB_CYC with debounce); no backpressure.
module hatch_seq
  import hatch_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 1000,
  parameter int unsigned FRAME_SEC  = 3,
  parameter int unsigned COLD_LIMIT = 5,
  parameter int unsigned LAST_FRAME = FRAME_HATCHED,
  parameter int unsigned FAIL_FRAME = FRAME_FAILED,
  parameter int unsigned DEB_CYC    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st_sw,
  input  logic       temp_in,
  output logic [3:0] num,
  output logic       st_out,
  output logic       temp_warn,
  output logic       done,
  output logic       fail
);

  localparam int unsigned SW = cnt_w(CLK_HZ);
  localparam int unsigned FW = cnt_w(FRAME_SEC);
  localparam int unsigned CW = cnt_w(COLD_LIMIT);
  localparam logic [3:0] LAST_NUM = 4'(LAST_FRAME);
  localparam logic [3:0] FAIL_NUM = 4'(FAIL_FRAME);

  logic st_s;
  logic tok_s;

  hatch_in_cond #(.DEB_CYC(DEB_CYC)) u_st_cond (
    .clk (clk),
    .rst (rst),
    .raw (st_sw),
    .cond(st_s)
  );

  hatch_in_cond #(.DEB_CYC(DEB_CYC)) u_tok_cond (
    .clk (clk),
    .rst (rst),
    .raw (temp_in),
    .cond(tok_s)
  );

  hatch_state_t  state, state_n;
  logic [SW-1:0] sec_cnt;
  logic [FW-1:0] frame_cnt, frame_n;
  logic [CW-1:0] cold_cnt, cold_n;
  logic [3:0]    num_n;
  logic          tick;

  assign tick = (sec_cnt == SW'(CLK_HZ - 1));

  always_comb begin
    state_n = state;
    frame_n = frame_cnt;
    cold_n  = cold_cnt;
    num_n   = num;
    if (!st_s) begin
      state_n = IDLE;
      frame_n = '0;
      cold_n  = '0;
      num_n   = FRAME_EGG;
    end else begin
      case (state)
        IDLE: begin
          state_n = INCUBATE;
          frame_n = '0;
          num_n   = FRAME_EGG;
        end
        INCUBATE: begin
          // A cold reading outranks a same-cycle tick: no advance on the way into PAUSE.
          if (!tok_s) begin
            state_n = PAUSE;
          end else if (tick) begin
            if (frame_cnt == FW'(FRAME_SEC - 1)) begin
              frame_n = '0;
              num_n   = num + 4'd1;
              if (num + 4'd1 == LAST_NUM) begin
                state_n = HATCHED;
              end
            end else begin
              frame_n = frame_cnt + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (tok_s) begin
            state_n = INCUBATE;
            cold_n  = '0;
          end else if (tick) begin
            if (cold_cnt == CW'(COLD_LIMIT - 1)) begin
              state_n = FAILED;
              num_n   = FAIL_NUM;
              cold_n  = '0;
            end else begin
              cold_n = cold_cnt + 1'b1;
            end
          end
        end
        HATCHED: num_n = LAST_NUM;
        FAILED:  num_n = FAIL_NUM;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sec_cnt   <= '0;
      frame_cnt <= '0;
      cold_cnt  <= '0;
      num       <= FRAME_EGG;
      st_out    <= 1'b0;
      temp_warn <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_n;
      cold_cnt  <= cold_n;
      num       <= num_n;
      st_out    <= (state_n != IDLE);
      temp_warn <= (state_n == PAUSE);
      done      <= (state_n == HATCHED);
      fail      <= (state_n == FAILED);
      // Second timebase restarts from zero each time a run begins.
      if (state == IDLE || tick) begin
        sec_cnt <= '0;
      end else begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hatch_seq.sv
// Randomized self-checking bench for hatch_seq against a warm-seconds reference model.
module tb_hatch_seq;

  localparam int CLK_HZ     = 4;
  localparam int FRAME_SEC  = 2;
  localparam int COLD_LIMIT = 3;
  localparam int LAST       = 9;
  localparam int FAILF      = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       st_sw;
  logic       temp_in;
  logic [3:0] num;
  logic       st_out;
  logic       temp_warn;
  logic       done;
  logic       fail;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hatch_seq #(
    .CLK_HZ    (CLK_HZ),
    .FRAME_SEC (FRAME_SEC),
    .COLD_LIMIT(COLD_LIMIT),
    .LAST_FRAME(LAST),
    .FAIL_FRAME(FAILF),
    .DEB_CYC   (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .st_sw    (st_sw),
    .temp_in  (temp_in),
    .num      (num),
    .st_out   (st_out),
    .temp_warn(temp_warn),
    .done     (done),
    .fail     (fail)
  );

  // Reference model: total warm seconds decide the frame; cold seconds decide failure.
  typedef enum {M_OFF, M_WARM, M_COLD, M_HATCH, M_DEAD} mode_t;
  mode_t mode;
  int    warm_sec;
  int    cold_sec;
  int    phase;
  logic  st_d1, st_d2, tp_d1, tp_d2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_num();
    case (mode)
      M_WARM, M_COLD: return warm_sec / FRAME_SEC;
      M_HATCH:        return LAST;
      M_DEAD:         return FAILF;
      default:        return 0;
    endcase
  endfunction

  task automatic model_reset();
    mode     = M_OFF;
    warm_sec = 0;
    cold_sec = 0;
    phase    = 0;
    st_d1 = 1'b0; st_d2 = 1'b0; tp_d1 = 1'b0; tp_d2 = 1'b0;
  endtask

  task automatic model_edge();
    logic st_e, tp_e;
    bit   sec_end;
    st_e    = st_d2;
    tp_e    = tp_d2;
    sec_end = (mode != M_OFF) && (phase == CLK_HZ - 1);
    phase   = (mode == M_OFF) ? 0 : (phase + 1) % CLK_HZ;
    st_d2 = st_d1; st_d1 = st_sw;
    tp_d2 = tp_d1; tp_d1 = temp_in;
    if (!st_e) begin
      mode     = M_OFF;
      warm_sec = 0;
      cold_sec = 0;
    end else begin
      case (mode)
        M_OFF: mode = M_WARM;
        M_WARM: begin
          if (!tp_e) mode = M_COLD;
          else if (sec_end) begin
            warm_sec++;
            if (warm_sec == LAST * FRAME_SEC) mode = M_HATCH;
          end
        end
        M_COLD: begin
          if (tp_e) begin
            mode     = M_WARM;
            cold_sec = 0;
          end else if (sec_end) begin
            cold_sec++;
            if (cold_sec == COLD_LIMIT) mode = M_DEAD;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic cycle(input logic s, input logic t);
    st_sw   = s;
    temp_in = t;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("num", num, exp_num());
    check_eq("st_out", st_out, mode != M_OFF);
    check_eq("temp_warn", temp_warn, mode == M_COLD);
    check_eq("done", done, mode == M_HATCH);
    check_eq("fail", fail, mode == M_DEAD);
  endtask

  task automatic restart();
    repeat (3) cycle(1'b0, 1'b1);
  endtask

  task automatic warm_until(input int target);
    for (int i = 0; i < 200 && exp_num() != target; i++) cycle(1'b1, 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    st_sw   = 1'b0;
    temp_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_num", num, 0);
    check_eq("rst_st_out", st_out, 0);
    check_eq("rst_warn", temp_warn, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_fail", fail, 0);
    rst = 1'b0;

    // Switch off: nothing moves whatever the temperature does.
    repeat (20) cycle(1'b0, 1'($urandom_range(0, 1)));

    // Full warm run to the hatched frame.
    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, 1'b1);
      if (i == 1) check_eq("pre_start", st_out, 0);
      if (i == 2) check_eq("start_lat", st_out, 1);
      if (i == 10) check_eq("first_adv", num, 1);
    end
    check_eq("hatch_num", num, LAST);
    check_eq("hatch_done", done, 1);

    // Restart from HATCHED, then a cold spell short of failure at frame 4.
    restart();
    check_eq("restart_blank", st_out, 0);
    warm_until(4);
    check_eq("reach_num4", num, 4);
    repeat (8) cycle(1'b1, 1'b0);
    check_eq("cold_hold_num", num, 4);
    check_eq("cold_no_fail", fail, 0);
    for (int i = 0; i < 120 && mode != M_HATCH; i++) cycle(1'b1, 1'b1);
    check_eq("resume_hatch", done, 1);

    // Cold timeout at frame 2; the failure latches.
    restart();
    warm_until(2);
    repeat (14) cycle(1'b1, 1'b0);
    check_eq("dead_fail", fail, 1);
    check_eq("dead_num", num, FAILF);
    check_eq("dead_warn", temp_warn, 0);
    repeat (10) cycle(1'b1, 1'b1);
    check_eq("dead_latched", fail, 1);

    // Random segments of switch and temperature levels.
    for (int seg = 0; seg < 40; seg++) begin
      logic s, t;
      int   len;
      s   = ($urandom_range(0, 9) != 0);
      t   = ($urandom_range(0, 2) != 0);
      len = $urandom_range(1, 12);
      repeat (len) cycle(s, t);
    end

    // Asynchronous reset while paused at frame 6.
    restart();
    warm_until(6);
    check_eq("reach_num6", num, 6);
    for (int i = 0; i < 6 && mode != M_COLD; i++) cycle(1'b1, 1'b0);
    check_eq("pause_warn", temp_warn, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_num", num, 0);
    check_eq("arst_st_out", st_out, 0);
    check_eq("arst_warn", temp_warn, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_fail", fail, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 1'b1);
      if (i == 2) check_eq("post_rst_start", st_out, 1);
      if (i == 2) check_eq("post_rst_num", num, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
